calc_engine: RTL and testbench

- Parametrised successor of the keypad calculator core: a decimal-entry, chained-operator integer calculator.
- Adds a configurable datapath width and digit limit, an equals key, sticky overflow and error flags, and an optional multi-cycle divider.
- Sits between the keypad scanner (4-bit key code plus level `key_pressed`) and the display driver.

---
 rtl/calc_engine_if.sv | 28 ++
 rtl/calc_engine.sv | 261 ++++++++++++++++++++++++++
 tb/tb_calc_engine.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_engine_if.sv
`default_nettype none
// ============================================================================
//  Module   : calc_engine_if
//  Purpose  : Keypad-to-calculator-to-display bundle. Master side is the
//             keypad scanner / display driver, slave side is calc_engine.
//  Revision : 1.0  initial release
// ============================================================================
interface calc_engine_if #(
  parameter int WIDTH = 16
);
  logic             key_pressed;
  logic [3:0]       keypad_out;
  logic [WIDTH-1:0] reg_display;
  logic             busy;
  logic             ovf;
  logic             err;

  modport master (
    output key_pressed, keypad_out,
    input  reg_display, busy, ovf, err
  );

  modport slave (
    input  key_pressed, keypad_out,
    output reg_display, busy, ovf, err
  );
endinterface
`default_nettype wire

// File: rtl/calc_engine.sv
`default_nettype none
// ============================================================================
//  Module   : calc_engine
//  Purpose  : Decimal-entry, chained-operator unsigned integer calculator.
//             Digits build an argument; each operator key applies the pending
//             operator to the running result; F (equals) shows the result and
//             lets the next digit start a fresh calculation.
//  Options  : CALC_DIVIDE_EN - builds the restoring divider (key D, DIVIDE
//             state, busy and err). Undefined: key D is ignored, busy=err=0.
//  Revision : 1.0  initial release
// ============================================================================
module calc_engine #(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 4
) (
  input  wire logic    clk,
  input  wire logic    rst,
  calc_engine_if.slave bus
);

  localparam int CNT_W     = $clog2(MAX_DIGITS + 1);
  localparam int EXT_W     = WIDTH + 4;
  localparam int DIV_CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_CLEAR    = 3'd0,
    S_READ     = 3'd1,
    S_DIGIT    = 3'd2,
    S_CALC     = 3'd3,
    S_DIVIDE   = 3'd4,
    S_DISP_ARG = 3'd5,
    S_DISP_RES = 3'd6,
    S_ERROR    = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    OP_PLUS  = 3'd0,
    OP_MINUS = 3'd1,
    OP_MUL   = 3'd2,
    OP_DIV   = 3'd3,
    OP_EQ    = 3'd4
  } op_t;

  state_t           state;
  op_t              op;
  op_t              op_next;
  logic [WIDTH-1:0] arg;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] display;
  logic [CNT_W-1:0] digit_cnt;
  logic [3:0]       key_code;
  logic             key_prev;
  logic             fresh;
  logic             ovf_flag;

  logic               key_edge;
  logic [EXT_W-1:0]   arg_ext;
  logic [EXT_W-1:0]   appended;
  logic               digit_ok;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;

`ifdef CALC_DIVIDE_EN
  logic [WIDTH-1:0]     div_rem;
  logic [WIDTH-1:0]     div_quo;
  logic [WIDTH-1:0]     div_dvsr;
  logic [DIV_CNT_W-1:0] div_cnt;
  logic                 div_busy;
  logic                 div_err;
  logic [WIDTH:0]       rem_shift;
  logic [WIDTH:0]       rem_sub;
  logic                 rem_take;
`endif

  // Key edge detect, digit-append candidate and the arithmetic results.
  always_comb begin
    key_edge = bus.key_pressed & ~key_prev;
    arg_ext  = {4'b0000, arg};
    // arg*10 + key, wide enough that it can never wrap
    appended = (arg_ext << 3) + (arg_ext << 1) + {{WIDTH{1'b0}}, key_code};
    digit_ok = (digit_cnt < CNT_W'(MAX_DIGITS)) &&
               (appended <= {4'b0000, MAX_VAL});
    sum      = {1'b0, result} + {1'b0, arg};
    prod     = (2*WIDTH)'(result) * (2*WIDTH)'(arg);
  end

`ifdef CALC_DIVIDE_EN
  // One restoring-division step: shift in the next dividend bit, subtract
  // the divisor when it fits.
  always_comb begin
    rem_shift = {div_rem, div_quo[WIDTH-1]};
    rem_sub   = rem_shift - {1'b0, div_dvsr};
    rem_take  = (rem_shift >= {1'b0, div_dvsr});
  end
`endif

  // Main controller: key capture, argument entry, operator evaluation,
  // division sequencing and the registered display/flag outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_CLEAR;
      op        <= OP_PLUS;
      op_next   <= OP_PLUS;
      arg       <= '0;
      result    <= '0;
      display   <= '0;
      digit_cnt <= '0;
      key_code  <= '0;
      key_prev  <= 1'b0;
      fresh     <= 1'b0;
      ovf_flag  <= 1'b0;
`ifdef CALC_DIVIDE_EN
      div_rem   <= '0;
      div_quo   <= '0;
      div_dvsr  <= '0;
      div_cnt   <= '0;
      div_busy  <= 1'b0;
      div_err   <= 1'b0;
`endif
    end else begin
      key_prev <= bus.key_pressed;

      case (state)
        S_CLEAR: begin
          arg       <= '0;
          result    <= '0;
          digit_cnt <= '0;
          display   <= '0;
          ovf_flag  <= 1'b0;
          op        <= OP_PLUS;
          fresh     <= 1'b0;
`ifdef CALC_DIVIDE_EN
          div_err   <= 1'b0;
`endif
          state     <= S_READ;
        end

        S_READ: begin
          if (key_edge) begin
            key_code <= bus.keypad_out;
            case (bus.keypad_out)
              4'hA: begin op_next <= OP_PLUS;  state <= S_CALC; end
              4'hB: begin op_next <= OP_MINUS; state <= S_CALC; end
              4'hC: begin op_next <= OP_MUL;   state <= S_CALC; end
`ifdef CALC_DIVIDE_EN
              4'hD: begin op_next <= OP_DIV;   state <= S_CALC; end
`else
              4'hD: state <= S_READ;
`endif
              4'hE: state <= S_CLEAR;
              4'hF: begin op_next <= OP_EQ;    state <= S_CALC; end
              default: state <= S_DIGIT;
            endcase
          end
        end

        S_DIGIT: begin
          if (digit_ok) begin
            arg       <= appended[WIDTH-1:0];
            digit_cnt <= digit_cnt + 1'b1;
          end
          // first digit after equals starts a new calculation
          if (fresh) begin
            result <= '0;
            fresh  <= 1'b0;
          end
          state <= S_DISP_ARG;
        end

        S_CALC: begin
          arg       <= '0;
          digit_cnt <= '0;
          if (op_next == OP_EQ) begin
            op    <= OP_PLUS;
            fresh <= 1'b1;
          end else begin
            op    <= op_next;
            fresh <= 1'b0;
          end
          state <= S_DISP_RES;
          case (op)
            OP_PLUS: begin
              result <= sum[WIDTH-1:0];
              if (sum[WIDTH]) ovf_flag <= 1'b1;
            end
            OP_MINUS: begin
              result <= result - arg;
              if (arg > result) ovf_flag <= 1'b1;
            end
            OP_MUL: begin
              result <= prod[WIDTH-1:0];
              if (|prod[2*WIDTH-1:WIDTH]) ovf_flag <= 1'b1;
            end
`ifdef CALC_DIVIDE_EN
            OP_DIV: begin
              if (arg == '0) begin
                div_err <= 1'b1;
                display <= '0;
                state   <= S_ERROR;
              end else begin
                div_rem  <= '0;
                div_quo  <= result;
                div_dvsr <= arg;
                div_cnt  <= '0;
                div_busy <= 1'b1;
                state    <= S_DIVIDE;
              end
            end
`endif
            default: result <= result;
          endcase
        end

`ifdef CALC_DIVIDE_EN
        S_DIVIDE: begin
          if (div_cnt == DIV_CNT_W'(WIDTH)) begin
            // remainder is discarded
            result   <= div_quo;
            div_busy <= 1'b0;
            state    <= S_DISP_RES;
          end else begin
            div_quo <= {div_quo[WIDTH-2:0], rem_take};
            div_rem <= rem_take ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
            div_cnt <= div_cnt + 1'b1;
          end
        end

        S_ERROR: begin
          display <= '0;
          if (key_edge && (bus.keypad_out == 4'hE)) state <= S_CLEAR;
        end
`endif

        S_DISP_ARG: begin
          display <= arg;
          state   <= S_READ;
        end

        S_DISP_RES: begin
          display <= result;
          state   <= S_READ;
        end

        default: state <= S_CLEAR;
      endcase
    end
  end

  assign bus.reg_display = display;
  assign bus.ovf         = ovf_flag;
`ifdef CALC_DIVIDE_EN
  assign bus.busy        = div_busy;
  assign bus.err         = div_err;
`else
  assign bus.busy        = 1'b0;
  assign bus.err         = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_calc_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_calc_engine
//  Purpose  : Self-checking bench for calc_engine (WIDTH=16, MAX_DIGITS=4).
//             Key presses are mirrored into an arithmetic reference model;
//             display and flags are compared after each key's latency.
//             Honours CALC_DIVIDE_EN the same way as the design.
//  Revision : 1.0  initial release
// ============================================================================
module tb_calc_engine;

  localparam int     WIDTH      = 16;
  localparam int     MAX_DIGITS = 4;
  localparam longint MAXV       = (longint'(1) << WIDTH) - 1;
`ifdef CALC_DIVIDE_EN
  localparam bit     DIV_EN     = 1'b1;
`else
  localparam bit     DIV_EN     = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  calc_engine_if #(.WIDTH(WIDTH)) bus();

  calc_engine #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state: op 0=plus 1=minus 2=mul 3=div
  longint m_arg, m_res, m_disp;
  int     m_cnt, m_op;
  bit     m_fresh, m_ovf, m_err, m_errmode;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_clear();
    m_arg = 0; m_res = 0; m_disp = 0; m_cnt = 0; m_op = 0;
    m_fresh = 0; m_ovf = 0; m_err = 0; m_errmode = 0;
  endtask

  task automatic model_key(input int k);
    if (m_errmode) begin
      if (k == 14) model_clear();
    end else if (k <= 9) begin
      if (m_fresh) begin m_res = 0; m_fresh = 0; end
      if (m_cnt < MAX_DIGITS && m_arg * 10 + k <= MAXV) begin
        m_arg = m_arg * 10 + k;
        m_cnt++;
      end
      m_disp = m_arg;
    end else if (k == 14) begin
      model_clear();
    end else if (k == 13 && !DIV_EN) begin
      // ignored key
    end else begin
      case (m_op)
        0: begin
          if (m_res + m_arg > MAXV) m_ovf = 1;
          m_res = (m_res + m_arg) & MAXV;
        end
        1: begin
          if (m_arg > m_res) m_ovf = 1;
          m_res = (m_res - m_arg) & MAXV;
        end
        2: begin
          if (m_res * m_arg > MAXV) m_ovf = 1;
          m_res = (m_res * m_arg) & MAXV;
        end
        default: begin
          if (m_arg == 0) begin
            m_err = 1; m_errmode = 1;
          end else begin
            m_res = m_res / m_arg;
          end
        end
      endcase
      m_arg = 0; m_cnt = 0;
      m_fresh = (k == 15);
      case (k)
        10: m_op = 0;
        11: m_op = 1;
        12: m_op = 2;
        13: m_op = 3;
        default: m_op = 0;
      endcase
      m_disp = m_errmode ? 0 : m_res;
    end
  endtask

  // Press key k, check output after its latency, optionally keep it held
  // (with a code change) for 'hold' cycles, optionally bounce the key
  // while a division is running.
  task automatic press(input int k, input int hold, input bit glitch);
    bit     errm, opkey, divx, derr, early_ok;
    longint old_disp;
    int     bc;
    errm     = m_errmode;
    opkey    = (k >= 10) && (k != 14) && ((k != 13) || DIV_EN);
    divx     = !errm && opkey && (m_op == 3) && (m_arg != 0);
    derr     = !errm && opkey && (m_op == 3) && (m_arg == 0);
    early_ok = !errm && !divx && !derr && (k != 14);
    old_disp = m_disp;
    @(negedge clk);
    bus.key_pressed = 1'b1;
    bus.keypad_out  = 4'(k);
    @(posedge clk);
    model_key(k);
    bc = 0;
    if (divx) begin
      for (int i = 1; i <= WIDTH + 3; i++) begin
        @(posedge clk); #1;
        if (bus.busy) bc++;
        if (i == WIDTH + 2) check("div_latency_hold", bus.reg_display, old_disp);
        if (glitch && i == 4) bus.key_pressed = 1'b0;
        if (glitch && i == 6) begin
          bus.key_pressed = 1'b1;
          bus.keypad_out  = 4'd5;
        end
      end
      check("div_busy_cycles", longint'((bc >= WIDTH) && (bc <= WIDTH + 1)), 1);
    end else begin
      @(posedge clk); #1;
      if (early_ok) check("latency_hold", bus.reg_display, old_disp);
      @(posedge clk); #1;
    end
    check("display", bus.reg_display, m_disp);
    check("ovf", bus.ovf, m_ovf);
    check("err", bus.err, m_err);
    check("busy_idle", bus.busy, 0);
    if (hold > 0) begin
      bus.keypad_out = 4'((k + 3) % 10);
      repeat (hold) @(posedge clk);
      #1;
      check("held_key", bus.reg_display, m_disp);
    end
    @(negedge clk);
    bus.key_pressed = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  function automatic int hexval(input byte c);
    if (c >= "0" && c <= "9") return int'(c - "0");
    return int'(c - "A") + 10;
  endfunction

  task automatic press_str(input string s);
    for (int i = 0; i < s.len(); i++) press(hexval(s[i]), 0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_display", bus.reg_display, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_ovf", bus.ovf, 0);
    check("rst_err", bus.err, 0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r, k;
    rst             = 1'b1;
    bus.key_pressed = 1'b0;
    bus.keypad_out  = 4'h0;
    model_clear();
    do_reset();

    // digit entry and the digit limit
    press_str("123");
    check("seq_123", bus.reg_display, 123);
    press_str("E12345");
    check("seq_1234_limit", bus.reg_display, 1234);
    press_str("E7A99999");
    check("seq_9999", bus.reg_display, 9999);

    // chaining, equals and fresh start
    press_str("E25C4F");
    check("seq_mul_100", bus.reg_display, 100);
    check("seq_mul_ovf", bus.ovf, 0);
    press_str("7");
    check("seq_fresh_7", bus.reg_display, 7);
    press_str("A3F");
    check("seq_fresh_sum", bus.reg_display, 10);

    // wrap and overflow
    press_str("E3B5F");
    check("seq_wrap", bus.reg_display, 65534);
    check("seq_wrap_ovf", bus.ovf, 1);
    press_str("E");
    check("seq_clear_ovf", bus.ovf, 0);
    press_str("9999C99F");
    check("seq_mul_wrap", bus.reg_display, 6861);
    check("seq_mul_ovf1", bus.ovf, 1);

`ifdef CALC_DIVIDE_EN
    press_str("E100D7F");
    check("seq_div_14", bus.reg_display, 14);
    press_str("E5D0F");
    check("seq_div0_err", bus.err, 1);
    press_str("3");
    check("seq_err_ignore", bus.reg_display, 0);
    press_str("E");
    check("seq_err_clear", bus.err, 0);

    // a key edge during DIVIDE is dropped
    press_str("E200D9");
    press(15, 0, 1'b1);
    check("seq_div_glitch", bus.reg_display, 22);

    // reset in the middle of a division
    press_str("E100D7");
    @(negedge clk);
    bus.key_pressed = 1'b1;
    bus.keypad_out  = 4'hF;
    repeat (6) @(posedge clk);
    #1;
    check("div_running", bus.busy, 1);
    do_reset();
    @(negedge clk);
    bus.key_pressed = 1'b0;
    repeat (2) @(posedge clk);
`else
    press_str("E12D");
    check("seq_d_ignored", bus.reg_display, 12);
`endif

    // long hold with a code change is a single key
    press_str("E");
    press(5, 20, 1'b0);
    check("seq_hold_once", bus.reg_display, 5);

    // randomized key stream
    press_str("E");
    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 55)      k = int'($urandom_range(0, 9));
      else if (r < 92) k = 10 + int'($urandom_range(0, 4));
      else             k = 14;
      if (k == 14 && r >= 92) k = 14;
      else if (k == 14) k = 15;
      press(k, 0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
